// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - signed 8-bit to 7-segment converter with multiplexed 4-digit scan
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero hundreds/tens digits)
module display_scan_controller #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Value,
  input  logic       Load,
  output logic       Busy,
  output logic       Done,
  output logic [6:0] Segments,
  output logic [3:0] DigitEnable
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_MINUS = 7'b1000000;
  localparam logic [6:0]  SEG_ZERO  = 7'b0111111;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_conv_neg;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_iter;

  logic        r_disp_neg;
  logic [3:0]  r_disp_hund;
  logic [3:0]  r_disp_tens;
  logic [3:0]  r_disp_units;

  logic [15:0] r_scan_cnt;
  logic [3:0]  r_digit_en;
  logic [6:0]  r_segments;

  logic [7:0]  w_mag;
  logic [11:0] w_bcd_adj;
  logic [11:0] w_bcd_shift;
  logic        w_commit;
  logic        w_neg_next;
  logic [3:0]  w_hund_next;
  logic [3:0]  w_tens_next;
  logic [3:0]  w_units_next;
  logic        w_scan_wrap;
  logic [3:0]  w_digit_en_next;
  logic [6:0]  w_hund_seg;
  logic [6:0]  w_tens_seg;
  logic [6:0]  w_units_seg;
  logic [6:0]  w_segments_next;

  // BCD digit to segment pattern; codes 10..15 never occur and show nothing
  function automatic logic [6:0] f_digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_digit_seg = 7'b0111111;
      4'd1:    f_digit_seg = 7'b0000110;
      4'd2:    f_digit_seg = 7'b1011011;
      4'd3:    f_digit_seg = 7'b1001111;
      4'd4:    f_digit_seg = 7'b1100110;
      4'd5:    f_digit_seg = 7'b1101101;
      4'd6:    f_digit_seg = 7'b1111101;
      4'd7:    f_digit_seg = 7'b0000111;
      4'd8:    f_digit_seg = 7'b1111111;
      4'd9:    f_digit_seg = 7'b1101111;
      default: f_digit_seg = 7'b0000000;
    endcase
  endfunction

  // Double-dabble correction: a digit of 5 or more gets +3 before the shift
  function automatic logic [3:0] f_adj(input logic [3:0] d);
    f_adj = (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Magnitude as unsigned 8 bits so that -128 becomes 128
  assign w_mag       = Value[7] ? (~Value + 8'd1) : Value;
  assign w_bcd_adj   = {f_adj(r_bcd[11:8]), f_adj(r_bcd[7:4]), f_adj(r_bcd[3:0])};
  assign w_bcd_shift = {w_bcd_adj[10:0], r_bin[7]};
  assign w_commit    = (r_state == CONVERT) && (r_iter == 3'd7);

  // Display contents as they will be after this edge, so the segment register
  // picks up a commit on the very edge it happens
  assign w_neg_next   = w_commit ? r_conv_neg         : r_disp_neg;
  assign w_hund_next  = w_commit ? w_bcd_shift[11:8]  : r_disp_hund;
  assign w_tens_next  = w_commit ? w_bcd_shift[7:4]   : r_disp_tens;
  assign w_units_next = w_commit ? w_bcd_shift[3:0]   : r_disp_units;

  assign w_scan_wrap     = (r_scan_cnt == SCAN_LAST);
  assign w_digit_en_next = w_scan_wrap ? {r_digit_en[2:0], r_digit_en[3]} : r_digit_en;

  // Per-position segment patterns with optional leading-zero blanking
  always_comb begin
    w_hund_seg  = f_digit_seg(w_hund_next);
    w_tens_seg  = f_digit_seg(w_tens_next);
    w_units_seg = f_digit_seg(w_units_next);
`ifdef LEADING_ZERO_BLANK_EN
    if (w_hund_next == 4'd0) begin
      w_hund_seg = 7'b0000000;
      if (w_tens_next == 4'd0) begin
        w_tens_seg = 7'b0000000;
      end
    end
`else
`endif
  end

  // Select the pattern for the position that will be enabled after this edge
  always_comb begin
    w_segments_next = 7'b0000000;
    case (w_digit_en_next)
      4'b0001: w_segments_next = w_units_seg;
      4'b0010: w_segments_next = w_tens_seg;
      4'b0100: w_segments_next = w_hund_seg;
      4'b1000: w_segments_next = w_neg_next ? SEG_MINUS : 7'b0000000;
      default: w_segments_next = 7'b0000000;
    endcase
  end

  // Conversion FSM: capture on Load, eight shift-add-3 steps, atomic commit
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_conv_neg   <= 1'b0;
      r_bin        <= 8'd0;
      r_bcd        <= 12'd0;
      r_iter       <= 3'd0;
      r_disp_neg   <= 1'b0;
      r_disp_hund  <= 4'd0;
      r_disp_tens  <= 4'd0;
      r_disp_units <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Load) begin
            r_conv_neg <= Value[7];
            r_bin      <= w_mag;
            r_bcd      <= 12'd0;
            r_iter     <= 3'd0;
            r_busy     <= 1'b1;
            r_state    <= CONVERT;
          end
        end
        CONVERT: begin
          r_bcd  <= w_bcd_shift;
          r_bin  <= {r_bin[6:0], 1'b0};
          r_iter <= r_iter + 3'd1;
          if (w_commit) begin
            r_disp_neg   <= r_conv_neg;
            r_disp_hund  <= w_bcd_shift[11:8];
            r_disp_tens  <= w_bcd_shift[7:4];
            r_disp_units <= w_bcd_shift[3:0];
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Free-running scan: position and its segment pattern update together
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_scan_cnt <= 16'd0;
      r_digit_en <= 4'b0001;
      r_segments <= SEG_ZERO;
    end else begin
      r_scan_cnt <= w_scan_wrap ? 16'd0 : (r_scan_cnt + 16'd1);
      r_digit_en <= w_digit_en_next;
      r_segments <= w_segments_next;
    end
  end

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Segments    = r_segments;
  assign DigitEnable = r_digit_en;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;

  localparam int SD = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Value;
  logic       Load;
  logic       Busy;
  logic       Done;
  logic [6:0] Segments;
  logic [3:0] DigitEnable;

  display_scan_controller #(.SCAN_DIV(SD)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Value       (Value),
    .Load        (Load),
    .Busy        (Busy),
    .Done        (Done),
    .Segments    (Segments),
    .DigitEnable (DigitEnable)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: edges since reset, pending conversion, committed value
  int         m_n;
  bit         m_busy;
  int         m_k;
  logic [7:0] m_pend;
  int         m_disp;
  bit         m_done;
  logic [6:0] pat [0:9];

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at edge %0d: observed %b expected %b", tag, m_n, obs, exp);
  endtask

  function automatic logic [6:0] exp_seg(input int p, input int v);
    int mag, h, t, u;
    logic [6:0] s;
    mag = (v < 0) ? -v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    s = 7'b0000000;
    case (p)
      0: s = pat[u];
      1: s = pat[t];
      2: s = pat[h];
      default: s = (v < 0) ? 7'b1000000 : 7'b0000000;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (p == 2 && h == 0) s = 7'b0000000;
    if (p == 1 && h == 0 && t == 0) s = 7'b0000000;
`endif
    return s;
  endfunction

  task automatic tick(input bit ld, input logic [7:0] val);
    bit acc;
    Load  = ld;
    Value = val;
    @(posedge Clock);
    m_n++;
    m_done = 1'b0;
    acc = ld && !m_busy;
    if (m_busy && m_n == m_k + 8) begin
      m_disp = int'($signed(m_pend));
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    if (acc) begin
      m_busy = 1'b1;
      m_k    = m_n;
      m_pend = val;
    end
    #1;
    Load = 1'b0;
    chk("busy",     7'(Busy),        7'(m_busy));
    chk("done",     7'(Done),        7'(m_done));
    chk("digit_en", 7'(DigitEnable), 7'(1 << ((m_n / SD) % 4)));
    chk("segments", Segments,        exp_seg((m_n / SD) % 4, m_disp));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},     7'(Busy),        7'd0);
    chk({tag, "_done"},     7'(Done),        7'd0);
    chk({tag, "_digit_en"}, 7'(DigitEnable), 7'b0001);
    chk({tag, "_segments"}, Segments,        7'b0111111);
  endtask

  task automatic do_reset(input int hold);
    Reset = 1'b1;
    Load  = 1'b0;
    #1;
    reset_checks("rst_async");
    repeat (hold) @(posedge Clock);
    #1;
    reset_checks("rst_held");
    Reset  = 1'b0;
    m_n    = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_disp = 0;
  endtask

  initial begin
    pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011; pat[3] = 7'b1001111;
    pat[4] = 7'b1100110; pat[5] = 7'b1101101; pat[6] = 7'b1111101; pat[7] = 7'b0000111;
    pat[8] = 7'b1111111; pat[9] = 7'b1101111;
    Reset = 1'b1;
    Load  = 1'b0;
    Value = 8'h00;
    m_k = 0;
    m_pend = 8'h00;
    #2;
    do_reset(2);

    // -13, loaded on the first edge after reset
    tick(1'b1, 8'hF3);
    repeat (11) tick(1'b0, 8'h00);

    // -128
    tick(1'b1, 8'h80);
    repeat (10) tick(1'b0, 8'h00);

    // 127 then an ignored Load, one ignored on the commit edge, one accepted in the Done cycle
    tick(1'b1, 8'h7F);
    tick(1'b0, 8'h7F);
    tick(1'b0, 8'h7F);
    tick(1'b1, 8'h05);
    repeat (4) tick(1'b0, 8'h05);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    repeat (10) tick(1'b0, 8'h00);

    // Reset aborts a conversion of 42
    tick(1'b1, 8'h2A);
    repeat (3) tick(1'b0, 8'h2A);
    do_reset(1);
    repeat (12) tick(1'b0, 8'h00);

    // Steady value 8 across several full scan rotations
    tick(1'b1, 8'h08);
    repeat (40) tick(1'b0, 8'h00);

    // Load of zero coinciding with a scan wrap
    for (int i = 0; i < SD && ((m_n + 1) % SD) != 0; i++) tick(1'b0, 8'h00);
    tick(1'b1, 8'h00);
    repeat (20) tick(1'b0, 8'h00);

    // -1
    tick(1'b1, 8'hFF);
    repeat (12) tick(1'b0, 8'h00);

    // Random loads and values
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 5) == 0), 8'($urandom));
    end
    repeat (12) tick(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter SCAN_DIV, default 1000, is the number of Clock cycles each digit position stays enabled; the legal range is 1..65535.
REQ-002 Port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port Value, input, 8 bits: two's-complement number to display, sampled on Load.
REQ-005 Port Load, input, 1 bit: request to convert Value.
REQ-006 Port Busy, output, 1 bit: high while a conversion is in progress.
REQ-007 Port Done, output, 1 bit: one-cycle pulse when new display data is committed.
REQ-008 Port Segments, output, 7 bits: segment drive in {g,f,e,d,c,b,a} order, active-high; digit 0 is 7'b0111111 and minus is 7'b1000000.
REQ-009 Port DigitEnable, output, 4 bits: one-hot, active-high; [0] units, [1] tens, [2] hundreds, [3] sign.

Function
REQ-010 The block SHALL have the states IDLE and CONVERT; Busy SHALL be 1 exactly when the state is CONVERT.
REQ-011 In IDLE, Load=1 at edge k SHALL capture the sign of Value and its 8-bit unsigned magnitude (-128 gives 128), then enter CONVERT.
REQ-012 CONVERT SHALL run 8 shift-add-3 (double-dabble) iterations, one per edge k+1..k+8, on a 12-bit BCD working register.
REQ-013 At edge k+8 the block SHALL copy the sign flag and the hundreds, tens and units digits atomically into the display registers, return to IDLE, and drive Done=1 for that one cycle.
REQ-014 Load while Busy=1 SHALL be ignored with no side effects; Load in the cycle where Done=1 SHALL be accepted, since the state is IDLE then.
REQ-015 Scanning SHALL run continuously, independent of conversion, always from the display registers; a conversion SHALL NOT disturb the displayed digits before its commit.
REQ-016 A scan counter SHALL count 0..SCAN_DIV-1; at its terminal count it SHALL wrap to 0 and advance DigitEnable in the order [0]->[1]->[2]->[3]->[0].
REQ-017 Segments and DigitEnable SHALL be registered and change on the same edge; no cycle may show a new position with the old segment pattern.
REQ-018 Digit patterns SHALL be as follows. 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-019 The sign position SHALL show 1000000 when the committed value is negative and 0000000 otherwise.
REQ-020 A BCD digit value of 10..15 (unreachable) SHALL display 0000000.

Reset
REQ-021 While Reset=1, the state SHALL be IDLE, Busy=0, Done=0, the scan counter 0, and DigitEnable=4'b0001.
REQ-022 While Reset=1, the display registers SHALL hold a non-negative zero, and Segments SHALL show the units pattern for 0 (0111111).
REQ-023 Reset asserted mid-conversion SHALL abort that conversion with no commit and no Done pulse.
REQ-024 After Reset deasserts, the first Load SHALL be accepted on the first rising edge.

Configuration
REQ-025 With macro LEADING_ZERO_BLANK_EN defined, the hundreds digit SHALL be blank (0000000) when it is 0, and the tens digit SHALL be blank when both hundreds and tens are 0.
REQ-026 Under LEADING_ZERO_BLANK_EN, the units digit SHALL never be blanked.
REQ-027 Without LEADING_ZERO_BLANK_EN, all three numeric positions SHALL show their digit, including leading zeros; sign behaviour SHALL be identical in both builds.

Verification
REQ-028 Scenario: Value=8'hF3 (-13) with Load for one cycle -> Busy high 8 cycles, Done at the 8th edge. Required display: sign 1000000, tens 0000110, units 1001111; hundreds 0000000 with the macro, 0111111 without it.
REQ-029 Scenario: Value=8'h80 -> display -128. Required: sign 1000000, hundreds 0000110, tens 1011011, units 1111111.
REQ-030 Scenario: Value=8'h7F, then Load with Value=8'h05 issued 3 cycles later -> the second Load is ignored; display shows 127 with sign blank, and exactly one Done pulse occurs.
REQ-031 Scenario: Reset pulsed 4 cycles after Load with Value=8'h2A -> no Done pulse; afterwards Busy=0, DigitEnable=0001 and Segments=0111111.
REQ-032 Scenario: SCAN_DIV=4, steady value 8 -> DigitEnable sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles. Segments per position: units 1111111, sign 0000000; hundreds and tens 0000000 with the macro, 0111111 without it.
REQ-033 Scenario: Load with Value=8'h00 asserted in the same cycle as a scan wrap -> the scan step is unaffected, and the commit updates the display 8 edges later without skipping a position.
